mem_1r1w_masked_32x64_ctrl: RTL and testbench
=============================================

# mem_1r1w_masked_32x64_ctrl

Controller in front of `mem_1r1w_masked_32x64`, the 32x64 one-read/one-write macro wrapper with 8-bit byte mask. After reset it zero-initialises all 32 entries. It then round-robin arbitrates two masked-write requesters onto the single write port and serves one read requester with fixed one-cycle response latency. A read whose address collides with the write granted in the same cycle is held off, because macro read-during-write data is undefined.

## Interface
Parameters:
- `DEPTH`, 32, entries; `ADDR_W` = $clog2(DEPTH) = 5
- `WIDTH`, 64, data bits
- `MASK_GRAN`, 8, bits per mask bit; `MASK_W` = WIDTH/MASK_GRAN = 8

Ports:
- `clock`  in  1  single clock; also drives the macro's `R0_clk`/`W0_clk` at top level
- `reset`  in  1  asynchronous, active-high
- `init_done`  out  1  high once the zero sweep completes
- `wa_valid`, `wb_valid`  in  1  write request, requester A / B
- `wa_ready`, `wb_ready`  out  1  write accepted this cycle
- `wa_addr`, `wb_addr`  in  ADDR_W  write address
- `wa_data`, `wb_data`  in  WIDTH  write data
- `wa_mask`, `wb_mask`  in  MASK_W  byte enables, 1 = write
- `rd_valid`  in  1  read request
- `rd_ready`  out  1  read accepted this cycle
- `rd_addr`  in  ADDR_W  read address
- `rsp_valid`  out  1  read data valid; no backpressure
- `rsp_data`  out  WIDTH  read data
- `R0_addr`, `R0_en`  out  ADDR_W, 1  macro read port
- `R0_data`  in  WIDTH  macro read data, one cycle after `R0_en`
- `W0_addr`, `W0_en`, `W0_data`, `W0_mask`  out  ADDR_W, 1, WIDTH, MASK_W  macro write port

## Operation
- **States:**
  - INIT: reset state. `init_cnt` starts at 0. Each cycle drives `W0_en`=1, `W0_addr`=`init_cnt`, `W0_data`=0, `W0_mask`=all ones, then increments `init_cnt`.
  - After writing address DEPTH-1, INIT moves to RUN.
  - RUN is terminal until reset.
- **INIT blocking:** in INIT, `wa_ready`, `wb_ready` and `rd_ready` are 0 and `R0_en` is 0.
- **Write arbitration (RUN):**
  - Round-robin pointer `prio`, reset value A.
  - Only one valid requester: grant it.
  - Both valid: grant `prio`.
  - After any grant, `prio` points to the other requester. No grant leaves `prio` unchanged.
  - The granted requester sees ready=1. `W0_en`=1 with its addr, data and mask passed through unmodified. `ready` depends combinationally on `valid`s and state only.
- **Read (RUN):**
  - `rd_ready` = 1 unless a write is granted this cycle with `W0_addr` == `rd_addr`.
  - On `rd_valid && rd_ready`: `R0_en`=1, `R0_addr`=`rd_addr`.
  - A collision stalls the read one cycle. It issues next cycle, when the macro returns the new data.
- **Response:** registered `rsp_valid` = read issued last cycle. `rsp_data` = `R0_data` passed straight through when `rsp_valid`, else 0.
- **Mask width:** `MASK_W` bits map 1:1 to the macro mask; no expansion in this block.

## Timing
- **Reset values:**
  - `init_done`=0, `rsp_valid`=0, `prio`=A, `init_cnt`=0.
  - While `reset` is high, all enables and readies are forced to 0 combinationally.
- **Init timing:** the first init write occurs in the first clock cycle after reset deasserts. Addresses 0..31 are written in 32 consecutive cycles. `init_done` rises at the edge ending the cycle that wrote address 31, and the first RUN request can be accepted in that same following cycle.
- **Throughput:** one write and one read per cycle. Read latency is 1 cycle (accept at edge t, `rsp_valid` high in cycle t+1).
- **Read-after-write:** a write accepted at edge t is visible to a read issued at t+1 or later.
- **Reset mid-operation:**
  - Asynchronous reset aborts everything and clears `rsp_valid` immediately.
  - A read in flight is dropped.
  - The sweep restarts at address 0.
  - Memory contents before re-init are don't-care.
- **Counter width:** `init_cnt` is ADDR_W+1 bits so the DEPTH-1 terminal value is detected without wrap.

## Structure
- **Package `mem_ctrl_pkg`:** `ADDR_W`, `MASK_W`, state enum `{ST_INIT, ST_RUN}`, requester id enum `{REQ_A, REQ_B}`.
- **Sub-module `rr_arb2`:** 2-input round-robin arbiter holding `prio`.
  - Inputs: `clock`, `reset`, `en`, `req[1:0]`.
  - Outputs: one-hot `gnt[1:0]`.
  - `en`=0 forces `gnt`=0 and freezes `prio`.
- **Top level:** instantiates `rr_arb2`, the INIT counter/FSM, the collision compare and the response register.

## Test plan
- **Init sweep:** deassert reset, then observe.
  - Required: `W0_en` high for exactly 32 cycles, addresses 0..31 in order, data 0, mask 8'hFF.
  - Required: `init_done` rises after the last init write; all readies stay 0 until then.
  - After init, read address 17 -> `rsp_data`=0 one cycle later.
- **Round-robin:** A and B both valid for 4 cycles, addresses 1 and 2.
  - Required grants: A, B, A, B.
  - Then B alone for 2 cycles -> B granted both cycles; `prio` becomes A.
- **Masked write:** write address 5, data 64'h1122334455667788, mask 8'h0F, then read address 5.
  - Required: `rsp_data`=64'h0000000055667788.
- **Collision:** write address 9 (data 64'hDEAD, mask 8'hFF) and read address 9 in the same cycle.
  - Required: `rd_ready`=0 that cycle and the read is accepted the next cycle.
  - Required: `rsp_data`=64'hDEAD.
  - Variant: read address 10 in the same cycle is accepted immediately.
- **Back-to-back reads:** reads of addresses 0..31 on consecutive cycles.
  - Required: `rsp_valid` continuously high for 32 cycles starting one cycle after the first read.
  - Required: data in address order.
- **Reset mid-operation:** assert reset while `rsp_valid`=1 and during an init sweep at `init_cnt`=12.
  - Required: `rsp_valid` drops immediately.
  - Required: after release the sweep restarts at address 0 and `init_done` rises again only after all 32 writes.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and sizes for the 32x64 masked 1R1W macro controller.
package mem_ctrl_pkg;

    localparam int ADDR_W = $clog2(32);
    localparam int MASK_W = 64 / 8;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; prio names the requester that wins a tie.
import mem_ctrl_pkg::*;

module rr_arb2 (
    input  logic       clock,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    req_id_t prio;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req[0] && (!req[1] || prio == REQ_A)) begin
                gnt[0] = 1'b1;
            end else if (req[1]) begin
                gnt[1] = 1'b1;
            end
        end
    end

    // The winner drops to lowest priority; idle cycles keep the pointer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prio <= REQ_A;
        end else if (gnt[0]) begin
            prio <= REQ_B;
        end else if (gnt[1]) begin
            prio <= REQ_A;
        end
    end

endmodule

// File: rtl/mem_1r1w_masked_32x64_ctrl.sv
// Controller for the 32x64 masked 1R1W macro: zero sweep after reset, then
// round-robin write arbitration and a one-cycle-latency read port.
import mem_ctrl_pkg::*;

module mem_1r1w_masked_32x64_ctrl #(
    parameter int DEPTH     = 32,
    parameter int WIDTH     = 64,
    parameter int MASK_GRAN = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    output logic                         init_done,

    input  logic                         wa_valid,
    output logic                         wa_ready,
    input  logic [$clog2(DEPTH)-1:0]     wa_addr,
    input  logic [WIDTH-1:0]             wa_data,
    input  logic [WIDTH/MASK_GRAN-1:0]   wa_mask,

    input  logic                         wb_valid,
    output logic                         wb_ready,
    input  logic [$clog2(DEPTH)-1:0]     wb_addr,
    input  logic [WIDTH-1:0]             wb_data,
    input  logic [WIDTH/MASK_GRAN-1:0]   wb_mask,

    input  logic                         rd_valid,
    output logic                         rd_ready,
    input  logic [$clog2(DEPTH)-1:0]     rd_addr,
    output logic                         rsp_valid,
    output logic [WIDTH-1:0]             rsp_data,

    output logic [$clog2(DEPTH)-1:0]     R0_addr,
    output logic                         R0_en,
    input  logic [WIDTH-1:0]             R0_data,

    output logic [$clog2(DEPTH)-1:0]     W0_addr,
    output logic                         W0_en,
    output logic [WIDTH-1:0]             W0_data,
    output logic [WIDTH/MASK_GRAN-1:0]   W0_mask
);

    localparam int AW = $clog2(DEPTH);
    localparam int MW = WIDTH / MASK_GRAN;
    // One spare bit so the last sweep index is seen without wrapping.
    localparam logic [AW:0] LAST_IDX = (AW + 1)'(DEPTH - 1);

    state_t      state;
    logic [AW:0] init_cnt;
    logic        in_init;
    logic        run_en;
    logic [1:0]  gnt;
    logic        wr_grant;
    logic        collide;
    logic        rd_issue;
    logic        vld_p1;

    assign in_init   = (state == ST_INIT);
    assign run_en    = (state == ST_RUN) && !reset;
    assign init_done = (state == ST_RUN);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else if (in_init) begin
            init_cnt <= init_cnt + (AW + 1)'(1);
            if (init_cnt == LAST_IDX) begin
                state <= ST_RUN;
            end
        end
    end

    rr_arb2 u_arb (
        .clock (clock),
        .reset (reset),
        .en    (run_en),
        .req   ({wb_valid, wa_valid}),
        .gnt   (gnt)
    );

    assign wa_ready = gnt[0];
    assign wb_ready = gnt[1];
    assign wr_grant = gnt[0] || gnt[1];

    always_comb begin
        W0_en   = 1'b0;
        W0_addr = wa_addr;
        W0_data = wa_data;
        W0_mask = wa_mask;
        if (!reset && in_init) begin
            W0_en   = 1'b1;
            W0_addr = init_cnt[AW-1:0];
            W0_data = '0;
            W0_mask = {MW{1'b1}};
        end else if (gnt[1]) begin
            W0_en   = 1'b1;
            W0_addr = wb_addr;
            W0_data = wb_data;
            W0_mask = wb_mask;
        end else if (gnt[0]) begin
            W0_en   = 1'b1;
        end
    end

    // Macro read-during-write data is undefined, so same-address reads wait a cycle.
    assign collide  = wr_grant && (W0_addr == rd_addr);
    assign rd_ready = run_en && !collide;
    assign rd_issue = rd_valid && rd_ready;
    assign R0_en    = rd_issue;
    assign R0_addr  = rd_addr;

    // p1: macro read data returns one cycle after issue.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= rd_issue;
        end
    end

    assign rsp_valid = vld_p1;
    assign rsp_data  = vld_p1 ? R0_data : '0;

endmodule

// File: tb/tb_mem_1r1w_masked_32x64_ctrl.sv
// Directed bench for the masked 1R1W controller with a behavioural macro.
import mem_ctrl_pkg::*;

module tb_mem_1r1w_masked_32x64_ctrl;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              init_done;
    logic              wa_valid = 1'b0, wb_valid = 1'b0, rd_valid = 1'b0;
    logic              wa_ready, wb_ready, rd_ready;
    logic [ADDR_W-1:0] wa_addr = '0, wb_addr = '0, rd_addr = '0;
    logic [63:0]       wa_data = '0, wb_data = '0;
    logic [MASK_W-1:0] wa_mask = '0, wb_mask = '0;
    logic              rsp_valid;
    logic [63:0]       rsp_data;
    logic [ADDR_W-1:0] R0_addr, W0_addr;
    logic              R0_en, W0_en;
    logic [63:0]       r0_q = '0;
    logic [63:0]       W0_data;
    logic [MASK_W-1:0] W0_mask;

    logic [63:0] mem [32];
    logic [63:0] exp_mem [32];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_1r1w_masked_32x64_ctrl dut (
        .clock(clk), .reset(reset), .init_done(init_done),
        .wa_valid(wa_valid), .wa_ready(wa_ready), .wa_addr(wa_addr), .wa_data(wa_data), .wa_mask(wa_mask),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data), .wb_mask(wb_mask),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .R0_addr(R0_addr), .R0_en(R0_en), .R0_data(r0_q),
        .W0_addr(W0_addr), .W0_en(W0_en), .W0_data(W0_data), .W0_mask(W0_mask)
    );

    // Behavioural macro; filled with a non-zero pattern during reset so the sweep matters.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) mem[i] <= {32'hA5A5A5A5, 32'(i)};
        end else begin
            if (W0_en)
                for (int b = 0; b < MASK_W; b++)
                    if (W0_mask[b]) mem[W0_addr][b*8 +: 8] <= W0_data[b*8 +: 8];
            if (R0_en) r0_q <= mem[R0_addr];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) exp_mem[i] = 64'h0;
        exp_mem[1]  = 64'h0000_AAAA_0000_0001;
        exp_mem[2]  = 64'h0000_BBBB_0000_0002;
        exp_mem[3]  = 64'h0000_0000_0000_3333;
        exp_mem[5]  = 64'h0000_0000_5566_7788;
        exp_mem[9]  = 64'h0000_0000_0000_BEEF;

        // Reset: every requester valid, nothing may be accepted.
        wa_valid = 1'b1; wb_valid = 1'b1; rd_valid = 1'b1;
        wa_mask = 8'hFF; wb_mask = 8'hFF; rd_addr = 5'd17;
        wb_addr = 5'd3; wb_data = 64'h3333;
        #1;
        chk("rst_state", {63'h0, init_done}, 64'h0);
        chk("rst_rsp", {63'h0, rsp_valid}, 64'h0);
        chk("rst_en", {60'h0, W0_en, R0_en, wa_ready, wb_ready}, 64'h0);
        tick; tick;
        chk("rst_hold", {62'h0, W0_en, rd_ready}, 64'h0);

        // Zero sweep, one address per cycle from the first cycle after release.
        reset = 1'b0;
        #1;
        for (int i = 0; i < 32; i++) begin
            chk("init_wr", {50'h0, W0_en, W0_addr, W0_mask}, {50'h0, 1'b1, 5'(i), 8'hFF});
            chk("init_data", W0_data, 64'h0);
            chk("init_blk", {59'h0, wa_ready, wb_ready, rd_ready, R0_en, init_done}, 64'h0);
            if (i == 31) wa_valid = 1'b0;
            tick;
        end

        // First RUN cycle: pending B write and read 17 accepted immediately.
        chk("init_done", {63'h0, init_done}, 64'h1);
        chk("run0_wr", {58'h0, wb_ready, wa_ready, W0_addr}, {58'h0, 2'b10, 5'd3});
        chk("run0_rd", {57'h0, rd_ready, R0_en, R0_addr}, {57'h0, 2'b11, 5'd17});
        tick;
        wb_valid = 1'b0; rd_valid = 1'b0;
        #1;
        chk("rd17_rsp", {63'h0, rsp_valid}, 64'h1);
        chk("rd17_data", rsp_data, 64'h0);

        // Round-robin: both valid for four cycles, then B alone, then a tie.
        wa_valid = 1'b1; wb_valid = 1'b1;
        wa_addr = 5'd1; wa_data = 64'h0000_AAAA_0000_0001;
        wb_addr = 5'd2; wb_data = 64'h0000_BBBB_0000_0002;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("rr_both", {57'h0, wb_ready, wa_ready, W0_addr},
                (k % 2 == 1) ? {57'h0, 2'b10, 5'd2} : {57'h0, 2'b01, 5'd1});
            tick;
        end
        wa_valid = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rr_b_only", {57'h0, wb_ready, wa_ready, W0_addr}, {57'h0, 2'b10, 5'd2});
            tick;
        end
        wa_valid = 1'b1;
        #1;
        chk("rr_prio_a", {62'h0, wb_ready, wa_ready}, 64'h1);
        tick;

        // Masked write: only the low four bytes land.
        wb_valid = 1'b0;
        wa_addr = 5'd5; wa_data = 64'h1122334455667788; wa_mask = 8'h0F;
        #1;
        chk("mw_wr", {55'h0, wa_ready, W0_mask}, {55'h0, 1'b1, 8'h0F});
        chk("mw_data", W0_data, 64'h1122334455667788);
        tick;
        wa_valid = 1'b0; rd_valid = 1'b1; rd_addr = 5'd5;
        #1;
        chk("mw_rd_acc", {63'h0, rd_ready}, 64'h1);
        tick;
        rd_valid = 1'b0;
        #1;
        chk("mw_rsp", rsp_data, 64'h0000000055667788);

        // Collision: same-address read is held off one cycle.
        wa_valid = 1'b1; wa_addr = 5'd9; wa_data = 64'hDEAD; wa_mask = 8'hFF;
        rd_valid = 1'b1; rd_addr = 5'd9;
        #1;
        chk("col_wr", {63'h0, wa_ready}, 64'h1);
        chk("col_hold", {62'h0, rd_ready, R0_en}, 64'h0);
        tick;
        wa_valid = 1'b0;
        #1;
        chk("col_issue", {61'h0, rd_ready, R0_en, rsp_valid}, {61'h0, 3'b110});
        tick;
        rd_valid = 1'b0;
        #1;
        chk("col_rsp", {63'h0, rsp_valid}, 64'h1);
        chk("col_data", rsp_data, 64'hDEAD);

        // Different address in the same cycle is not stalled.
        wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 64'hBEEF; wb_mask = 8'hFF;
        rd_valid = 1'b1; rd_addr = 5'd10;
        #1;
        chk("nocol", {61'h0, wb_ready, rd_ready, R0_en}, {61'h0, 3'b111});
        tick;
        wb_valid = 1'b0; rd_valid = 1'b0;
        #1;
        chk("nocol_rsp", {rsp_valid, rsp_data[62:0]}, {1'b1, 63'h0});

        // Back-to-back reads of every address.
        for (int i = 0; i < 32; i++) begin
            rd_valid = 1'b1; rd_addr = 5'(i);
            #1;
            chk("b2b_acc", {63'h0, rd_ready}, 64'h1);
            if (i > 0) begin
                chk("b2b_vld", {63'h0, rsp_valid}, 64'h1);
                chk("b2b_data", rsp_data, exp_mem[i-1]);
            end
            tick;
        end
        rd_valid = 1'b0;
        #1;
        chk("b2b_last", rsp_data, exp_mem[31]);
        chk("b2b_vld_last", {63'h0, rsp_valid}, 64'h1);
        tick;
        chk("b2b_idle", {63'h0, rsp_valid}, 64'h0);

        // Reset with a response in flight.
        rd_valid = 1'b1; rd_addr = 5'd2;
        #1;
        tick;
        rd_valid = 1'b0;
        #1;
        chk("mid_rsp_pre", rsp_data, exp_mem[2]);
        reset = 1'b1;
        #1;
        chk("mid_rsp_drop", {63'h0, rsp_valid}, 64'h0);
        chk("mid_rst_blk", {61'h0, init_done, W0_en, rd_ready}, 64'h0);
        tick;
        reset = 1'b0;
        #1;
        for (int i = 0; i <= 12; i++) begin
            chk("sweep1", {57'h0, init_done, W0_en, W0_addr}, {57'h0, 1'b0, 1'b1, 5'(i)});
            if (i < 12) tick;
        end

        // Reset again at init_cnt=12; the sweep starts over.
        reset = 1'b1;
        #1;
        chk("sweep_abort", {63'h0, W0_en}, 64'h0);
        tick;
        reset = 1'b0;
        #1;
        for (int i = 0; i < 32; i++) begin
            chk("sweep2", {57'h0, init_done, W0_en, W0_addr}, {57'h0, 1'b0, 1'b1, 5'(i)});
            tick;
        end
        chk("sweep2_done", {63'h0, init_done}, 64'h1);

        // Contents written before the restart are cleared by the sweep.
        rd_valid = 1'b1; rd_addr = 5'd2;
        #1;
        tick;
        rd_valid = 1'b0;
        #1;
        chk("reinit_rd", {rsp_valid, rsp_data[62:0]}, {1'b1, 63'h0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
